// File: rtl/pdp8_pkg.sv
// Shared types for the PDP-8 execution checker: decoded memory opcode,
// checker error codes and FSM states.
package pdp8_pkg;

    localparam int unsigned PDP_ADDR_WIDTH = 12;

    typedef struct packed {
        logic                      AND;
        logic                      TAD;
        logic                      ISZ;
        logic                      DCA;
        logic                      JMS;
        logic                      JMP;
        logic [PDP_ADDR_WIDTH-1:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ADDR     = 3'd1,
        ERR_TIMEOUT  = 3'd2,
        ERR_SPURIOUS = 3'd3,
        ERR_OVERLAP  = 3'd4,
        ERR_DATA     = 3'd5
    } chk_err_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2,
        WAIT_PC = 2'd3
    } chk_state_e;

    function automatic logic op_any(input pdp_mem_opcode_s op);
        return op.AND | op.TAD | op.ISZ | op.DCA | op.JMS | op.JMP;
    endfunction

    function automatic chk_state_e first_state(input pdp_mem_opcode_s op);
        if (op.AND || op.TAD || op.ISZ) return WAIT_RD;
        if (op.DCA || op.JMS)           return WAIT_WR;
        if (op.JMP)                     return WAIT_PC;
        return IDLE;
    endfunction

endpackage

// File: rtl/pdp8_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module pdp8_sat_counter
    import pdp8_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pdp8_exec_checker.sv
// Checks that each decoded PDP-8 memory-reference instruction produces the
// expected read/write/PC activity. Optional data checks: EXEC_CHK_DATA_EN.
module pdp8_exec_checker
    import pdp8_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  pdp_mem_opcode_s       pdp_mem_opcode,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    input  logic [DATA_WIDTH-1:0] exec_rd_data,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  chk_busy,
    output logic                  chk_done,
    output logic                  chk_err,
    output logic [2:0]            chk_err_code,
    output logic [ADDR_WIDTH-1:0] chk_err_addr,
    output logic [CNT_WIDTH-1:0]  chk_pass_cnt,
    output logic [CNT_WIDTH-1:0]  chk_fail_cnt
);

    localparam int unsigned TW = $clog2(MAX_WAIT + 1);

    chk_state_e            state_q, state_d;
    logic                  any_q, start;
    logic                  isz_q, isz_d, jms_q, jms_d;
    logic [ADDR_WIDTH-1:0] exp_q, exp_d, exp_inc, err_addr_q;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  step_ok, err_hit, done_d, pc_match, data_ok;
    chk_err_e              code_d, code_q;
    logic                  done_q, err_q;

    assign start    = op_any(pdp_mem_opcode) && !any_q;
    assign exp_inc  = exp_q + ADDR_WIDTH'(1);
    assign pc_match = (PC_value == (jms_q ? exp_inc : exp_q));

`ifdef EXEC_CHK_DATA_EN
    logic [ADDR_WIDTH-1:0] pc_cap_q;
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] rd_cap_q, rd_val, wr_exp;

    // Read data arrives the cycle after the request; use it live if the write follows at once.
    assign rd_val  = rd_pend_q ? exec_rd_data : rd_cap_q;
    assign wr_exp  = jms_q ? (DATA_WIDTH'(pc_cap_q) + DATA_WIDTH'(1)) : (rd_val + DATA_WIDTH'(1));
    assign data_ok = (exec_wr_data == wr_exp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_cap_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_cap_q  <= '0;
        end else begin
            if (start) pc_cap_q <= PC_value;
            rd_pend_q <= !start && (state_q == WAIT_RD) && (state_d == WAIT_WR);
            if (rd_pend_q) rd_cap_q <= exec_rd_data;
        end
    end
`else
    logic unused_data;
    assign data_ok     = 1'b1;
    assign unused_data = ^{exec_rd_data, exec_wr_data};
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state, step evaluation and error selection
    always_comb begin
        state_d = state_q;
        isz_d   = isz_q;
        jms_d   = jms_q;
        exp_d   = exp_q;
        timer_d = timer_q;
        step_ok = 1'b0;
        err_hit = 1'b0;
        done_d  = 1'b0;
        code_d  = ERR_NONE;
        if (start) begin
            // Overlap reports against the old check, then the new one starts immediately.
            if (state_q != IDLE) begin
                err_hit = 1'b1;
                code_d  = ERR_OVERLAP;
            end
            state_d = first_state(pdp_mem_opcode);
            isz_d   = pdp_mem_opcode.ISZ;
            jms_d   = pdp_mem_opcode.JMS;
            exp_d   = ADDR_WIDTH'(pdp_mem_opcode.mem_inst_addr);
            timer_d = TW'(MAX_WAIT);
        end else begin
            unique case (state_q)
                WAIT_RD: begin
                    if (exec_rd_req && (exec_rd_addr != exp_q)) begin
                        err_hit = 1'b1; code_d = ERR_ADDR;
                    end else if (exec_wr_req) begin
                        err_hit = 1'b1; code_d = ERR_SPURIOUS;
                    end else if (exec_rd_req) begin
                        step_ok = 1'b1;
                    end
                end
                WAIT_WR: begin
                    if (exec_wr_req && (exec_wr_addr != exp_q)) begin
                        err_hit = 1'b1; code_d = ERR_ADDR;
                    end else if (exec_rd_req) begin
                        err_hit = 1'b1; code_d = ERR_SPURIOUS;
                    end else if (exec_wr_req && !data_ok) begin
                        err_hit = 1'b1; code_d = ERR_DATA;
                    end else if (exec_wr_req) begin
                        step_ok = 1'b1;
                    end
                end
                WAIT_PC: begin
                    if (exec_rd_req || exec_wr_req) begin
                        err_hit = 1'b1; code_d = ERR_SPURIOUS;
                    end else if (pc_match) begin
                        step_ok = 1'b1;
                    end
                end
                default: ;
            endcase
            if (err_hit) begin
                state_d = IDLE;
            end else if (step_ok) begin
                if ((state_q == WAIT_RD) && isz_q) begin
                    state_d = WAIT_WR;
                    timer_d = TW'(MAX_WAIT);
                end else if ((state_q == WAIT_WR) && jms_q) begin
                    state_d = WAIT_PC;
                    timer_d = TW'(MAX_WAIT);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (state_q != IDLE) begin
                if (timer_q <= TW'(1)) begin
                    err_hit = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
        end
        if (state_d == IDLE) timer_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_q      <= 1'b0;
            isz_q      <= 1'b0;
            jms_q      <= 1'b0;
            exp_q      <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            any_q   <= op_any(pdp_mem_opcode);
            isz_q   <= isz_d;
            jms_q   <= jms_d;
            exp_q   <= exp_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_hit;
            if (err_hit) begin
                code_q     <= code_d;
                err_addr_q <= exp_q;
            end
        end
    end

    // Outputs
    always_comb begin
        chk_busy = (state_q != IDLE);
    end

    assign chk_done     = done_q;
    assign chk_err      = err_q;
    assign chk_err_code = code_q;
    assign chk_err_addr = err_addr_q;

    pdp8_sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (done_d),
        .count   (chk_pass_cnt)
    );

    pdp8_sat_counter #(.WIDTH(CNT_WIDTH)) u_fail_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_hit),
        .count   (chk_fail_cnt)
    );

endmodule

// File: tb/tb_pdp8_exec_checker.sv
// Directed, table-driven bench for pdp8_exec_checker plus hand sequences for
// timeout, data check, counter saturation and mid-check reset.
module tb_pdp8_exec_checker;
    import pdp8_pkg::*;

    localparam int OP_NONE = 0, OP_AND = 1, OP_TAD = 2, OP_ISZ = 3;
    localparam int OP_DCA = 4, OP_JMS = 5, OP_JMP = 6;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    pdp_mem_opcode_s opc;
    logic [11:0]     pc, ra, rdat, wa, wdat;
    logic            rd, wr;

    logic        busy, done, err;
    logic [2:0]  code;
    logic [11:0] eaddr;
    logic [15:0] pcnt, fcnt;
    logic        b_busy, b_done, b_err;
    logic [2:0]  b_code;
    logic [11:0] b_eaddr;
    logic [1:0]  b_pcnt, b_fcnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pdp8_exec_checker #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MAX_WAIT(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .pdp_mem_opcode(opc), .PC_value(pc),
        .exec_rd_req(rd), .exec_rd_addr(ra), .exec_rd_data(rdat),
        .exec_wr_req(wr), .exec_wr_addr(wa), .exec_wr_data(wdat),
        .chk_busy(busy), .chk_done(done), .chk_err(err), .chk_err_code(code),
        .chk_err_addr(eaddr), .chk_pass_cnt(pcnt), .chk_fail_cnt(fcnt)
    );

    pdp8_exec_checker #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MAX_WAIT(8), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .pdp_mem_opcode(opc), .PC_value(pc),
        .exec_rd_req(rd), .exec_rd_addr(ra), .exec_rd_data(rdat),
        .exec_wr_req(wr), .exec_wr_addr(wa), .exec_wr_data(wdat),
        .chk_busy(b_busy), .chk_done(b_done), .chk_err(b_err), .chk_err_code(b_code),
        .chk_err_addr(b_eaddr), .chk_pass_cnt(b_pcnt), .chk_fail_cnt(b_fcnt)
    );

    typedef struct {
        int op, ia, rd, ra, rdat, wr, wa, wdat, pc;
        int busy, done, err, code, eaddr, pcnt, fcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int op, ia, rdq, rad, rdd, wrq, wad, wdd, pcv,
                                input int eb, ed, ee, ec, ea, ep, ef);
        vec_t v;
        v.op = op; v.ia = ia; v.rd = rdq; v.ra = rad; v.rdat = rdd;
        v.wr = wrq; v.wa = wad; v.wdat = wdd; v.pc = pcv;
        v.busy = eb; v.done = ed; v.err = ee; v.code = ec; v.eaddr = ea;
        v.pcnt = ep; v.fcnt = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input int op, ia, rdq, rad, rdd, wrq, wad, wdd, pcv);
        opc = '0;
        opc.AND = (op == OP_AND); opc.TAD = (op == OP_TAD); opc.ISZ = (op == OP_ISZ);
        opc.DCA = (op == OP_DCA); opc.JMS = (op == OP_JMS); opc.JMP = (op == OP_JMP);
        opc.mem_inst_addr = 12'(ia);
        rd = 1'(rdq); ra = 12'(rad); rdat = 12'(rdd);
        wr = 1'(wrq); wa = 12'(wad); wdat = 12'(wdd);
        pc = 12'(pcv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int op, ia, rdq, rad, rdd, wrq, wad, wdd, pcv);
        drive(op, ia, rdq, rad, rdd, wrq, wad, wdd, pcv);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        drive(OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

        //          op      ia        rd ra       rdat     wr wa        wdat      pc        busy dn er cd ea      pc fc
        tbl.push_back(mk(OP_TAD, 12'o200, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 0, 0,       0, 0));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 0, 0,       0, 0));
        tbl.push_back(mk(OP_NONE, 0,      1, 12'o200, 0,       0, 0,        0,        0,        0, 1, 0, 0, 0,       1, 0));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        0,        0, 0, 0, 0, 0,       1, 0));
        tbl.push_back(mk(OP_DCA, 12'o100, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 0, 0,       1, 0));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       1, 12'o101,  0,        0,        0, 0, 1, 1, 12'o100, 1, 1));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        0,        0, 0, 0, 1, 12'o100, 1, 1));
        tbl.push_back(mk(OP_ISZ, 12'o300, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 1, 12'o100, 1, 1));
        tbl.push_back(mk(OP_NONE, 0,      1, 12'o300, 0,       0, 0,        0,        0,        1, 0, 0, 1, 12'o100, 1, 1));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       12'o7777, 0, 0,       0,        0,        1, 0, 0, 1, 12'o100, 1, 1));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       1, 12'o300,  12'o0000, 0,        0, 1, 0, 1, 12'o100, 2, 1));
        tbl.push_back(mk(OP_AND, 12'o050, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 1, 12'o100, 2, 1));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 1, 12'o100, 2, 1));
        tbl.push_back(mk(OP_JMS, 12'o060, 0, 0,       0,       0, 0,        0,        12'o057,  1, 0, 1, 4, 12'o050, 2, 2));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       1, 12'o060,  12'o060,  0,        1, 0, 0, 4, 12'o050, 2, 2));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        12'o061,  0, 1, 0, 4, 12'o050, 3, 2));
        tbl.push_back(mk(OP_JMP, 12'o400, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 4, 12'o050, 3, 2));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        12'o400,  0, 1, 0, 4, 12'o050, 4, 2));
        tbl.push_back(mk(OP_AND, 12'o050, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 4, 12'o050, 4, 2));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       1, 12'o050,  0,        0,        0, 0, 1, 3, 12'o050, 4, 3));
        tbl.push_back(mk(OP_TAD, 12'o070, 0, 0,       0,       0, 0,        0,        0,        1, 0, 0, 3, 12'o050, 4, 3));
        tbl.push_back(mk(OP_NONE, 0,      1, 12'o070, 0,       1, 12'o070,  0,        0,        0, 0, 1, 3, 12'o070, 4, 4));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        0,        0, 0, 0, 3, 12'o070, 4, 4));
        tbl.push_back(mk(OP_JMS, 12'o7777, 0, 0,      0,       0, 0,        0,        12'o7776, 1, 0, 0, 3, 12'o070, 4, 4));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       1, 12'o7777, 12'o7777, 0,        1, 0, 0, 3, 12'o070, 4, 4));
        tbl.push_back(mk(OP_NONE, 0,      0, 0,       0,       0, 0,        0,        12'o0000, 0, 1, 0, 3, 12'o070, 5, 4));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset err_code", code, 0);
        chk("reset pass_cnt", pcnt, 0);
        #3 reset_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            step(v.op, v.ia, v.rd, v.ra, v.rdat, v.wr, v.wa, v.wdat, v.pc);
            chk($sformatf("row%0d busy", i), busy, v.busy);
            chk($sformatf("row%0d done", i), done, v.done);
            chk($sformatf("row%0d err", i), err, v.err);
            chk($sformatf("row%0d code", i), code, v.code);
            chk($sformatf("row%0d err_addr", i), eaddr, v.eaddr);
            chk($sformatf("row%0d pass_cnt", i), pcnt, v.pcnt);
            chk($sformatf("row%0d fail_cnt", i), fcnt, v.fcnt);
        end
        chk("sat pass_cnt", b_pcnt, 3);
        chk("sat fail_cnt", b_fcnt, 3);

        // JMP never reaches its target: timeout exactly 8 cycles into WAIT_PC
        step(OP_JMP, 12'o400, 0, 0, 0, 0, 0, 0, 0);
        chk("jmp busy", busy, 1);
        drive(OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
        got = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (err) begin
                got = n;
                break;
            end
        end
        chk("jmp timeout latency", got, 8);
        chk("jmp timeout code", code, 2);
        chk("jmp timeout err_addr", eaddr, 12'o400);
        chk("jmp timeout fail_cnt", fcnt, 5);
        tick();

        // ISZ with a wrong increment in the written data
        step(OP_ISZ, 12'o300, 0, 0, 0, 0, 0, 0, 0);
        step(OP_NONE, 0, 1, 12'o300, 0, 0, 0, 0, 0);
        step(OP_NONE, 0, 0, 0, 12'o7777, 0, 0, 0, 0);
        step(OP_NONE, 0, 0, 0, 0, 1, 12'o300, 12'o0001, 0);
`ifdef EXEC_CHK_DATA_EN
        chk("isz data err", err, 1);
        chk("isz data code", code, 5);
        chk("isz data err_addr", eaddr, 12'o300);
        chk("isz data fail_cnt", fcnt, 6);
`else
        chk("isz nodata done", done, 1);
        chk("isz nodata err", err, 0);
        chk("isz nodata pass_cnt", pcnt, 6);
`endif
        step(OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during WAIT_WR of an ISZ
        step(OP_ISZ, 12'o300, 0, 0, 0, 0, 0, 0, 0);
        step(OP_NONE, 0, 1, 12'o300, 0, 0, 0, 0, 0);
        chk("isz in WAIT_WR busy", busy, 1);
        drive(OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset err", err, 0);
        chk("midreset code", code, 0);
        chk("midreset err_addr", eaddr, 0);
        chk("midreset pass_cnt", pcnt, 0);
        chk("midreset fail_cnt", fcnt, 0);
        tick();
        chk("in reset err", err, 0);
        #3 reset_n = 1'b1;
        tick();
        chk("post reset err", err, 0);
        chk("post reset done", done, 0);
        tick();
        chk("post reset idle err", err, 0);
        step(OP_DCA, 12'o100, 0, 0, 0, 0, 0, 0, 0);
        chk("post reset dca busy", busy, 1);
        step(OP_NONE, 0, 0, 0, 0, 1, 12'o100, 12'o1234, 0);
        chk("post reset dca done", done, 1);
        chk("post reset dca err", err, 0);
        chk("post reset pass_cnt", pcnt, 1);
        chk("post reset fail_cnt", fcnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pdp8_exec_checker.md
PDP8_EXEC_CHECKER -- requirements
Module: pdp8_exec_checker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12: memory data width.
REQ-003 SHALL have parameter MAX_WAIT, default 8: cycles allowed per expected event.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: pass/fail counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Ports:
 - clk  in  1  free-running clock.
 - reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have the remaining ports:
 - pdp_mem_opcode  in  pdp_mem_opcode_s  decoded memory instruction plus mem_inst_addr.
 - PC_value  in  ADDR_WIDTH  program counter.
 - exec_rd_req  in  1  memory read request.
 - exec_rd_addr  in  ADDR_WIDTH  read address.
 - exec_rd_data  in  DATA_WIDTH  read data (valid the cycle after exec_rd_req).
 - exec_wr_req  in  1  memory write request.
 - exec_wr_addr  in  ADDR_WIDTH  write address.
 - exec_wr_data  in  DATA_WIDTH  write data.
 - chk_busy  out  1  instruction under check.
 - chk_done  out  1  one-cycle pulse, check passed.
 - chk_err  out  1  one-cycle pulse, check failed.
 - chk_err_code  out  3  chk_err_e code, held until next error.
 - chk_err_addr  out  ADDR_WIDTH  captured mem_inst_addr of the failing instruction.
 - chk_pass_cnt, chk_fail_cnt  out  CNT_WIDTH  saturating totals.

Function
REQ-007 SHALL start a check on the 0->1 transition of OR(AND,TAD,ISZ,DCA,JMS,JMP), sampled at posedge clk; SHALL register opcode and mem_inst_addr (exp_addr).
REQ-008 SHALL use FSM states IDLE, WAIT_RD, WAIT_WR, WAIT_PC: AND/TAD -> WAIT_RD; ISZ -> WAIT_RD then WAIT_WR; DCA -> WAIT_WR; JMS -> WAIT_WR then WAIT_PC; JMP -> WAIT_PC.
REQ-009 WAIT_RD SHALL complete on exec_rd_req with exec_rd_addr==exp_addr; WAIT_WR on exec_wr_req with exec_wr_addr==exp_addr; WAIT_PC when PC_value==exp_addr (JMP) or exp_addr+1 mod 2^ADDR_WIDTH (JMS).
REQ-010 Last step complete SHALL pulse chk_done the next cycle, increment chk_pass_cnt, return to IDLE.
REQ-011 Request with wrong address in its expected state SHALL raise ERR_ADDR (1).
REQ-012 A wait-state timer SHALL reload to MAX_WAIT on each state entry; reaching 0 without completion SHALL raise ERR_TIMEOUT (2).
REQ-013 A read in WAIT_WR/WAIT_PC, or a write in WAIT_RD/WAIT_PC, SHALL raise ERR_SPURIOUS (3).
REQ-014 A new instruction start while not IDLE SHALL raise ERR_OVERLAP (4) for the old check, then begin checking the new instruction the same cycle.
REQ-015 Any error SHALL pulse chk_err one cycle, latch chk_err_code and chk_err_addr, increment chk_fail_cnt, and go to IDLE (except REQ-014).
REQ-016 Same-cycle read and write requests: the request matching the current state SHALL be evaluated; the other SHALL raise ERR_SPURIOUS; error wins over completion.
REQ-017 Counters SHALL saturate at all-ones; chk_done and chk_err SHALL never assert together.
REQ-018 chk_busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 On reset_n low, FSM SHALL enter IDLE; all outputs, counters, timer and captured fields SHALL be 0 (chk_err_code = ERR_NONE, 0), including mid-check.
REQ-020 No error or completion SHALL be reported for a check aborted by reset.

Configuration
REQ-021 With EXEC_CHK_DATA_EN defined: ISZ write data SHALL equal captured read data +1 mod 2^DATA_WIDTH, JMS write data SHALL equal captured PC_value +1; mismatch raises ERR_DATA (5).
REQ-022 Without EXEC_CHK_DATA_EN: no data capture or compare logic; code 5 never produced.

Structure
REQ-023 chk_err_e (ERR_NONE..ERR_DATA) and chk_state_e SHALL live in pdp8_pkg alongside pdp_mem_opcode_s.
REQ-024 Both counters SHALL be instances of sub-module pdp8_sat_counter (parameter WIDTH, inc input).

Verification
REQ-025 TAD addr 0o200, read at 0o200 two cycles later -> chk_done, pass_cnt=1.
REQ-026 ISZ 0o300, read 0o300 data 0o7777, write 0o300 data 0o0000 -> chk_done; with EXEC_CHK_DATA_EN, write data 0o0001 -> ERR_DATA, err_addr=0o300.
REQ-027 DCA 0o100, write at 0o101 -> chk_err, code 1, fail_cnt=1.
REQ-028 JMP 0o400, PC never reaches 0o400 -> chk_err code 2 exactly MAX_WAIT=8 cycles after entering WAIT_PC.
REQ-029 AND 0o050 then JMS 0o060 before read -> code 4 for AND; JMS write 0o060, PC=0o061 -> chk_done.
REQ-030 reset_n low during WAIT_WR of ISZ -> all outputs 0, no chk_err; next DCA checks normally.
